// File: rtl/register_writeback.sv
// register_writeback: sixteen 64-bit architectural registers, the writeback port from execute, and the busy scoreboard.
// Latency: a single-destination result is visible 1 cycle after accept; a special (second) destination lands 1 cycle later.
// Backpressure: wbReadyOut drops while a latched special write commits; stallOut blocks read-stage issue on RAW/WAW hazards.
//
// Ports:
//   clk, reset (sync, active-low)
//   wbValidIn/wbReadyOut, destRegIn/destValIn, destRegisterSpecial*  : writeback from execute
//   reserve*                                                         : destinations of the instruction issuing this cycle
//   sourceReg1*/sourceReg2*                                          : sources of the instruction waiting in the read stage
//   registerFileOut, busyOut, stallOut, wbDoneOut                    : state and status toward the read stage
module register_writeback #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wbValidIn,
    output logic                wbReadyOut,
    input  logic [0:3]          destRegIn,
    input  logic [DATA_W-1:0]   destValIn,
    input  logic                destRegisterSpecialValidIn,
    input  logic [0:3]          destRegisterSpecialIn,
    input  logic [DATA_W-1:0]   destValSpecialIn,
    input  logic                reserveValidIn,
    input  logic [0:3]          reserveRegIn,
    input  logic                reserveSpecialValidIn,
    input  logic [0:3]          reserveSpecialRegIn,
    input  logic [0:3]          sourceReg1In,
    input  logic                sourceReg1ValidIn,
    input  logic [0:3]          sourceReg2In,
    input  logic                sourceReg2ValidIn,
    output logic [DATA_W-1:0]   registerFileOut [NUM_REGS],
    output logic [NUM_REGS-1:0] busyOut,
    output logic                stallOut,
    output logic                wbDoneOut
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic                accept;
    logic                doneNext;
    logic [NUM_REGS-1:0] busyClr;
    logic [NUM_REGS-1:0] busySet;
    logic [NUM_REGS-1:0] busyNext;

    // Pending special write: the primary code is kept too, because both
    // busy bits are released together when the special value commits.
    logic [0:3]          primReg;
    logic [0:3]          specReg;
    logic [DATA_W-1:0]   specVal;

    // Hazard check uses the registered scoreboard only, so a clear at
    // edge N is first seen here in cycle N+1.
    assign stallOut = (sourceReg1ValidIn && busyOut[sourceReg1In])
                   || (sourceReg2ValidIn && busyOut[sourceReg2In])
                   || (reserveValidIn && busyOut[reserveRegIn])
                   || (reserveValidIn && reserveSpecialValidIn && busyOut[reserveSpecialRegIn]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        wbReadyOut = reset && (state == IDLE);
        accept     = wbValidIn && wbReadyOut;
        doneNext   = 1'b0;
        busyClr    = '0;
        busySet    = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (destRegisterSpecialValidIn) begin
                        stateNext = SECOND;
                    end else begin
                        busyClr[destRegIn] = 1'b1;
                        doneNext           = 1'b1;
                    end
                end
            end
            SECOND: begin
                stateNext        = IDLE;
                busyClr[primReg] = 1'b1;
                busyClr[specReg] = 1'b1;
                doneNext         = 1'b1;
            end
            default: stateNext = IDLE;
        endcase

        if (reserveValidIn && !stallOut) begin
            busySet[reserveRegIn] = 1'b1;
            if (reserveSpecialValidIn) begin
                busySet[reserveSpecialRegIn] = 1'b1;
            end
        end

        // Set applied after clear: a same-edge reserve keeps the bit busy.
        busyNext = (busyOut & ~busyClr) | busySet;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busyOut   <= '0;
            wbDoneOut <= 1'b0;
            primReg   <= '0;
            specReg   <= '0;
            specVal   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                registerFileOut[i] <= '0;
            end
        end else begin
            busyOut   <= busyNext;
            wbDoneOut <= doneNext;
            if (accept) begin
                registerFileOut[destRegIn] <= destValIn;
                if (destRegisterSpecialValidIn) begin
                    primReg <= destRegIn;
                    specReg <= destRegisterSpecialIn;
                    specVal <= destValSpecialIn;
                end
            end
            // Commits one edge after the primary, so on equal codes the
            // special value is what remains.
            if (state == SECOND) begin
                registerFileOut[specReg] <= specVal;
            end
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        wbValidIn;
    logic        wbReadyOut;
    logic [3:0]  destRegIn;
    logic [63:0] destValIn;
    logic        destRegisterSpecialValidIn;
    logic [3:0]  destRegisterSpecialIn;
    logic [63:0] destValSpecialIn;
    logic        reserveValidIn;
    logic [3:0]  reserveRegIn;
    logic        reserveSpecialValidIn;
    logic [3:0]  reserveSpecialRegIn;
    logic [3:0]  sourceReg1In;
    logic        sourceReg1ValidIn;
    logic [3:0]  sourceReg2In;
    logic        sourceReg2ValidIn;
    logic [63:0] rf [16];
    logic [15:0] busyOut;
    logic        stallOut;
    logic        wbDoneOut;

    int checks = 0;
    int errors = 0;

    register_writeback dut (
        .clk                        (clk),
        .reset                      (reset),
        .wbValidIn                  (wbValidIn),
        .wbReadyOut                 (wbReadyOut),
        .destRegIn                  (destRegIn),
        .destValIn                  (destValIn),
        .destRegisterSpecialValidIn (destRegisterSpecialValidIn),
        .destRegisterSpecialIn      (destRegisterSpecialIn),
        .destValSpecialIn           (destValSpecialIn),
        .reserveValidIn             (reserveValidIn),
        .reserveRegIn               (reserveRegIn),
        .reserveSpecialValidIn      (reserveSpecialValidIn),
        .reserveSpecialRegIn        (reserveSpecialRegIn),
        .sourceReg1In               (sourceReg1In),
        .sourceReg1ValidIn          (sourceReg1ValidIn),
        .sourceReg2In               (sourceReg2In),
        .sourceReg2ValidIn          (sourceReg2ValidIn),
        .registerFileOut            (rf),
        .busyOut                    (busyOut),
        .stallOut                   (stallOut),
        .wbDoneOut                  (wbDoneOut)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wbValidIn = 0; destRegIn = 0; destValIn = 0;
        destRegisterSpecialValidIn = 0; destRegisterSpecialIn = 0; destValSpecialIn = 0;
        reserveValidIn = 0; reserveRegIn = 0; reserveSpecialValidIn = 0; reserveSpecialRegIn = 0;
        sourceReg1In = 0; sourceReg1ValidIn = 0; sourceReg2In = 0; sourceReg2ValidIn = 0;
    endtask

    task automatic doReset();
        reset = 0;
        idle();
        tick();
        reset = 1;
    endtask

    function automatic int nonZeroExcept(input int skip);
        int n = 0;
        for (int i = 0; i < 16; i++)
            if (i != skip && rf[i] !== 64'd0) n++;
        return n;
    endfunction

    // ---------------- reference model ----------------
    // Architectural view: register array, set of busy registers, and a queue
    // of special writes still owed to the register file.
    typedef struct {
        logic [3:0]  p;
        logic [3:0]  s;
        logic [63:0] v;
    } pend_t;

    logic [63:0] mReg [16];
    logic [15:0] mBusy;
    bit          mDone;
    pend_t       mPend [$];

    function automatic bit mReady();
        return reset && (mPend.size() == 0);
    endfunction

    function automatic bit mStall();
        return (sourceReg1ValidIn && mBusy[sourceReg1In])
            || (sourceReg2ValidIn && mBusy[sourceReg2In])
            || (reserveValidIn && mBusy[reserveRegIn])
            || (reserveValidIn && reserveSpecialValidIn && mBusy[reserveSpecialRegIn]);
    endfunction

    task automatic modelEdge();
        bit          stall;
        bit          ready;
        logic [15:0] clr;
        logic [15:0] set;
        pend_t       e;
        stall = mStall();
        ready = mReady();
        clr = '0;
        set = '0;
        if (!reset) begin
            for (int i = 0; i < 16; i++) mReg[i] = 64'd0;
            mBusy = '0;
            mDone = 0;
            mPend.delete();
            return;
        end
        mDone = 0;
        if (mPend.size() > 0) begin
            e = mPend.pop_front();
            mReg[e.s] = e.v;
            clr[e.p] = 1'b1;
            clr[e.s] = 1'b1;
            mDone = 1;
        end else if (wbValidIn && ready) begin
            mReg[destRegIn] = destValIn;
            if (destRegisterSpecialValidIn) begin
                e.p = destRegIn;
                e.s = destRegisterSpecialIn;
                e.v = destValSpecialIn;
                mPend.push_back(e);
            end else begin
                clr[destRegIn] = 1'b1;
                mDone = 1;
            end
        end
        if (reserveValidIn && !stall) begin
            set[reserveRegIn] = 1'b1;
            if (reserveSpecialValidIn) set[reserveSpecialRegIn] = 1'b1;
        end
        mBusy = (mBusy & ~clr) | set;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit          spc;
        logic [3:0]  d;
        logic [63:0] dv;
        logic [3:0]  s;
        logic [63:0] sv;
        logic [3:0]  chkReg;
        logic [63:0] chkVal;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n;
        vecs[0] = '{1'b0, 4'd3,  64'hDEADBEEF_00000001, 4'd0, 64'd0,      4'd3,  64'hDEADBEEF_00000001, 1};
        vecs[1] = '{1'b1, 4'd0,  64'hAAAA,              4'd2, 64'hBBBB,   4'd2,  64'hBBBB,              2};
        vecs[2] = '{1'b1, 4'd4,  64'd1,                 4'd4, 64'd2,      4'd4,  64'd2,                 2};
        vecs[3] = '{1'b0, 4'd15, 64'hFFFFFFFF_FFFFFFFF, 4'd0, 64'd0,      4'd15, 64'hFFFFFFFF_FFFFFFFF, 1};
        vecs[4] = '{1'b1, 4'd8,  64'h1234,              4'd9, 64'h5678,   4'd8,  64'h1234,              2};

        // Reset
        reset = 0;
        idle();
        tick();
        #1;
        chk("ready_in_reset", wbReadyOut, 0);
        tick();
        reset = 1;
        chk("reset_busy", busyOut, 0);
        chk("reset_done", wbDoneOut, 0);
        chk("reset_regs_nonzero", nonZeroExcept(-1), 0);
        #1;
        chk("reset_ready", wbReadyOut, 1);
        chk("reset_stall", stallOut, 0);

        // Single writeback to reg 3
        wbValidIn = 1; destRegIn = 3; destValIn = 64'hDEADBEEF_00000001;
        tick();
        idle();
        chk("wb3_val", rf[3], 64'hDEADBEEF_00000001);
        chk("wb3_done", wbDoneOut, 1);
        chk("wb3_others", nonZeroExcept(3), 0);
        tick();
        chk("wb3_done_pulse", wbDoneOut, 0);

        // Table: latency and final contents
        for (int k = 0; k < 5; k++) begin
            wbValidIn = 1; destRegIn = vecs[k].d; destValIn = vecs[k].dv;
            destRegisterSpecialValidIn = vecs[k].spc;
            destRegisterSpecialIn = vecs[k].s; destValSpecialIn = vecs[k].sv;
            #1;
            chk($sformatf("vec%0d_ready", k), wbReadyOut, 1);
            tick();
            idle();
            #1;
            chk($sformatf("vec%0d_ready_n1", k), wbReadyOut, !vecs[k].spc);
            n = 1;
            while (!wbDoneOut && n < 6) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_latency", k), n, vecs[k].lat);
            chk($sformatf("vec%0d_value", k), rf[vecs[k].chkReg], vecs[k].chkVal);
            tick();
        end

        // RAW hazard on reg 5 released by writeback
        reserveValidIn = 1; reserveRegIn = 5;
        #1;
        chk("res5_stall", stallOut, 0);
        tick();
        idle();
        sourceReg1ValidIn = 1; sourceReg1In = 5;
        #1;
        chk("res5_busy", busyOut[5], 1);
        chk("raw5_stall", stallOut, 1);
        tick();
        #1;
        chk("raw5_stall_hold", stallOut, 1);
        wbValidIn = 1; destRegIn = 5; destValIn = 64'h55;
        #1;
        chk("raw5_stall_accept", stallOut, 1);
        tick();
        wbValidIn = 0;
        #1;
        chk("raw5_stall_clear", stallOut, 0);
        chk("raw5_val", rf[5], 64'h55);
        idle();

        // Special writeback with both destinations busy
        doReset();
        reserveValidIn = 1; reserveRegIn = 0; reserveSpecialValidIn = 1; reserveSpecialRegIn = 2;
        tick();
        idle();
        chk("spc_busy_set", busyOut, 16'h0005);
        wbValidIn = 1; destRegIn = 0; destValIn = 64'hAAAA;
        destRegisterSpecialValidIn = 1; destRegisterSpecialIn = 2; destValSpecialIn = 64'hBBBB;
        tick();
        idle();
        #1;
        chk("spc_n1_ready", wbReadyOut, 0);
        chk("spc_n1_reg0", rf[0], 64'hAAAA);
        chk("spc_n1_reg2", rf[2], 64'd0);
        chk("spc_n1_busy", busyOut, 16'h0005);
        chk("spc_n1_done", wbDoneOut, 0);
        tick();
        #1;
        chk("spc_n2_reg2", rf[2], 64'hBBBB);
        chk("spc_n2_busy", busyOut, 16'h0000);
        chk("spc_n2_done", wbDoneOut, 1);
        chk("spc_n2_ready", wbReadyOut, 1);
        tick();
        chk("spc_n3_done", wbDoneOut, 0);

        // Reserve and busy-clear of reg 7 at the same edge
        wbValidIn = 1; destRegIn = 7; destValIn = 64'h7;
        reserveValidIn = 1; reserveRegIn = 7;
        #1;
        chk("rw7_stall", stallOut, 0);
        tick();
        idle();
        chk("rw7_busy", busyOut[7], 1);
        chk("rw7_val", rf[7], 64'h7);

        // Reserve of already-busy reg 9 is refused
        reserveValidIn = 1; reserveRegIn = 9;
        tick();
        reserveSpecialValidIn = 1; reserveSpecialRegIn = 10;
        #1;
        chk("waw9_stall", stallOut, 1);
        tick();
        idle();
        chk("waw9_busy", busyOut, 16'h0280);

        // Reset during SECOND
        doReset();
        reserveValidIn = 1; reserveRegIn = 1; reserveSpecialValidIn = 1; reserveSpecialRegIn = 6;
        tick();
        idle();
        wbValidIn = 1; destRegIn = 1; destValIn = 64'h11;
        destRegisterSpecialValidIn = 1; destRegisterSpecialIn = 6; destValSpecialIn = 64'h66;
        tick();
        idle();
        chk("rs_reg1", rf[1], 64'h11);
        reset = 0;
        tick();
        reset = 1;
        #1;
        chk("rs_ready", wbReadyOut, 1);
        chk("rs_done", wbDoneOut, 0);
        chk("rs_busy", busyOut, 0);
        chk("rs_regs_nonzero", nonZeroExcept(-1), 0);
        tick();
        chk("rs_done_after", wbDoneOut, 0);
        chk("rs_reg6", rf[6], 64'd0);

        // Randomized against the model
        reset = 0;
        idle();
        modelEdge();
        tick();
        for (int c = 0; c < 600; c++) begin
            reset                      = ($urandom_range(0, 59) != 0);
            wbValidIn                  = $urandom_range(0, 1);
            destRegIn                  = 4'($urandom_range(0, 15));
            destValIn                  = {$urandom, $urandom};
            destRegisterSpecialValidIn = ($urandom_range(0, 2) == 0);
            destRegisterSpecialIn      = 4'($urandom_range(0, 15));
            destValSpecialIn           = {$urandom, $urandom};
            reserveValidIn             = ($urandom_range(0, 2) == 0);
            reserveRegIn               = 4'($urandom_range(0, 15));
            reserveSpecialValidIn      = $urandom_range(0, 1);
            reserveSpecialRegIn        = 4'($urandom_range(0, 15));
            sourceReg1In               = 4'($urandom_range(0, 15));
            sourceReg1ValidIn          = $urandom_range(0, 1);
            sourceReg2In               = 4'($urandom_range(0, 15));
            sourceReg2ValidIn          = $urandom_range(0, 1);
            #1;
            chk("rnd_ready", wbReadyOut, mReady());
            chk("rnd_stall", stallOut, mStall());
            modelEdge();
            tick();
            chk("rnd_busy", busyOut, mBusy);
            chk("rnd_done", wbDoneOut, mDone);
            for (int i = 0; i < 16; i++)
                chk($sformatf("rnd_reg%0d", i), rf[i], mReg[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_writeback.md
# register_writeback

Writeback end of the register-file interface. Owns the sixteen 64-bit architectural registers and drives them to the operand-read stage. Accepts results from execute through a valid/ready handshake, including the two-register special destination (RDX:RAX for IMUL). Keeps a per-register busy scoreboard, set when the read stage issues an instruction and cleared when its result is written back, and raises a stall toward the read stage on RAW or WAW hazards.

## Interface
- NUM_REGS, 16: architectural register count; register codes are 4 bits.
- DATA_W, 64: register width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wbValidIn  in  1  execute presents a result.
- wbReadyOut  out  1  block can accept a result this cycle.
- destRegIn  in  [0:3]  primary destination code.
- destValIn  in  [63:0]  primary result.
- destRegisterSpecialValidIn  in  1  a second destination is also written.
- destRegisterSpecialIn  in  [0:3]  second destination code.
- destValSpecialIn  in  [63:0]  second result.
- reserveValidIn  in  1  the read stage issues an instruction this cycle.
- reserveRegIn  in  [0:3]  primary destination of the issuing instruction.
- reserveSpecialValidIn  in  1  the issuing instruction also has a special destination.
- reserveSpecialRegIn  in  [0:3]  special destination of the issuing instruction.
- sourceReg1In, sourceReg2In  in  [0:3]  sources of the instruction waiting in the read stage.
- sourceReg1ValidIn, sourceReg2ValidIn  in  1  source-valid qualifiers.
- registerFileOut  out  [63:0] x16  current register contents.
- busyOut  out  [15:0]  scoreboard; bit n set means register n has a write pending.
- stallOut  out  1  hazard; the read stage must not issue.
- wbDoneOut  out  1  one-cycle pulse after a writeback fully completes.

## Operation
- States: IDLE and SECOND.
- wbReadyOut = reset && (state == IDLE).
- Accept condition: wbValidIn && wbReadyOut.

IDLE, on accept without the special destination:
- Write destValIn to reg[destRegIn].
- Clear busy[destRegIn].
- Stay in IDLE.

IDLE, on accept with the special destination:
- Write the primary register.
- Latch destRegisterSpecialIn and destValSpecialIn internally; upstream does not need to hold them.
- Go to SECOND.

SECOND:
- Write the latched special value to its register.
- Clear busy on both the primary and the special register.
- Return to IDLE.
- wbReadyOut is 0 for this entire cycle.

Write ordering and collisions:
- If the primary and special codes are equal, the special value is the final contents.
- Reserve: when reserveValidIn is 1 and stallOut is 0, set busy[reserveRegIn]; if reserveSpecialValidIn is also 1, set busy[reserveSpecialRegIn].
- If reserveValidIn is 1 while stallOut is 1, the reserve is ignored.
- A reserve and a busy-clear on the same register at the same edge: the reserve wins and busy stays 1.

stallOut is combinational and asserts when any of these holds:
- sourceReg1ValidIn && busy[sourceReg1In]
- sourceReg2ValidIn && busy[sourceReg2In]
- reserveValidIn && busy[reserveRegIn]
- reserveValidIn && reserveSpecialValidIn && busy[reserveSpecialRegIn]

No bypass: the read stage sees a written value only on registerFileOut in the cycle after the write edge.

## Timing
While reset is low at a rising edge:
- All registers go to 0.
- busyOut goes to 0.
- State goes to IDLE.
- wbDoneOut goes to 0.
- Any latched special write is discarded.

While reset is low, wbReadyOut is 0. stallOut is computed from the reset-valued scoreboard.

Reset asserted while in SECOND: the pending special write is dropped and busy bits are cleared.

Latency, single destination:
- Accept at edge N.
- registerFileOut and busyOut update after edge N.
- wbDoneOut is high in cycle N+1.

Latency, special destination:
- Primary register updated after edge N.
- Special register and both busy clears after edge N+1.
- wbDoneOut is high in cycle N+2.
- Maximum throughput is one special writeback every two cycles.

Busy-clear interaction:
- A reserve in the same cycle as an accept sees pre-edge busy values.
- A hazard cleared by the writeback at edge N deasserts stallOut in cycle N+1.

## Test plan
- Reset, then accept wbValidIn with destRegIn=3 and destValIn=0xDEADBEEF_00000001 -> reg[3] shows that value next cycle, wbDoneOut pulses once, all other registers stay 0.
- Reserve reg 5, then hold sourceReg1In=5 with sourceReg1ValidIn=1 -> stallOut=1 until writeback of reg 5 with 0x55, then stallOut=0 the cycle after and registerFileOut[5]=0x55.
- Special writeback with dest 0 = 0xAAAA and special 2 = 0xBBBB, with busy[0] and busy[2] both set -> wbReadyOut=0 for one cycle, reg[0] updates one cycle before reg[2], both busy bits clear after the second edge, wbDoneOut pulses at N+2.
- Special writeback with dest 4 = 1 and special 4 = 2 -> reg[4] ends at 2.
- Writeback clearing reg 7 in the same cycle as a new reserve of reg 7 -> busyOut[7]=1 afterward. Separately, a reserve of an already-busy reg 9 -> stallOut=1 and the scoreboard is unchanged.
- Reset asserted in SECOND after the primary write of reg 1 = 0x11 -> all registers 0, busyOut=0, no wbDoneOut pulse, wbReadyOut=1 in the first cycle after reset deasserts.
